// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready producers onto one FIFO write port.
// Each grant is locked for up to BURST beats, and a registered output stage carries the source index.
module fifo_rr_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 8,
  parameter int BURST      = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ*IN_NUM*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [DATA_WIDTH-1:0]              data_out [IN_NUM-1:0],
  output logic                               data_out_valid,
  input  logic                               data_out_ready,
  output logic [IDW-1:0]                     grant_id
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [0:0]     IDLE      = 1'b0;
  localparam logic [0:0]     LOCKED    = 1'b1;
  localparam logic [CW-1:0]  BURST_MAX = CW'(BURST);
  localparam logic [IDW-1:0] LAST_RST  = IDW'(NUM_REQ - 1);

  logic [0:0]            state;
  logic [CW-1:0]         burst_cnt;
  logic [CW-1:0]         burst_nxt;
  logic [IDW-1:0]        last;
  logic [IDW-1:0]        owner;
  logic                  slot_free;
  logic                  found;
  logic                  accept;
  logic [IDW-1:0]        winner;
  logic [IDW-1:0]        src;
  logic [DATA_WIDTH-1:0] src_data [IN_NUM-1:0];

  assign slot_free = !data_out_valid || data_out_ready;
  assign src       = (state == IDLE) ? winner : owner;
  assign accept    = |(req_valid & req_ready);
  assign burst_nxt = burst_cnt + 1'b1;

  // Rotating priority scan starting just after the last granted requester.
  always_comb begin : rr_scan
    logic [IDW:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  // Only the selected source ever sees ready; a full output slot holds everyone off.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (state == IDLE) begin
        if (found) req_ready[winner] = slot_free;
      end else begin
        req_ready[owner] = slot_free;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < IN_NUM; i++) src_data[i] = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (IDW'(r) == src) begin
        for (int i = 0; i < IN_NUM; i++)
          src_data[i] = req_data[(r*IN_NUM+i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output stage: loads on accept, drains to invalid when free and idle, holds when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_valid <= 1'b0;
      grant_id       <= '0;
      for (int i = 0; i < IN_NUM; i++) data_out[i] <= '0;
    end else if (slot_free) begin
      data_out_valid <= accept;
      if (accept) begin
        grant_id <= src;
        data_out <= src_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last      <= LAST_RST;
      owner     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            burst_cnt <= CW'(1);
            last      <= winner;
            owner     <= winner;
            if (BURST > 1) state <= LOCKED;
          end
        end
        default: begin
          if (accept) begin
            if (burst_nxt == BURST_MAX) begin
              state     <= IDLE;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_nxt;
            end
          end else if (slot_free && !req_valid[owner]) begin
            // Owner went quiet with the slot free: give the port back early.
            state     <= IDLE;
            burst_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed bench for fifo_rr_write_arbiter: one instance with BURST=4, one with BURST=1.
module tb_fifo_rr_write_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int IN  = 8;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst0, rst1;
  logic [NR*IN*DW-1:0]   rd0, rd1;
  logic [NR-1:0]         rv0, rv1;
  logic [NR-1:0]         rr0, rr1;
  logic [DW-1:0]         do0 [IN-1:0];
  logic [DW-1:0]         do1 [IN-1:0];
  logic                  dv0, dv1;
  logic                  ordy0, ordy1;
  logic [IDW-1:0]        gid0, gid1;

  int checks = 0;
  int errors = 0;

  fifo_rr_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IN_NUM(IN), .BURST(4)) dut0 (
    .clk(clk), .rst(rst0), .req_data(rd0), .req_valid(rv0), .req_ready(rr0),
    .data_out(do0), .data_out_valid(dv0), .data_out_ready(ordy0), .grant_id(gid0));

  fifo_rr_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IN_NUM(IN), .BURST(1)) dut1 (
    .clk(clk), .rst(rst1), .req_data(rd1), .req_valid(rv1), .req_ready(rr1),
    .data_out(do1), .data_out_valid(dv1), .data_out_ready(ordy1), .grant_id(gid1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int r, input int b, input int i);
    return 8'(r*64 + b*8 + i);
  endfunction

  function automatic logic [63:0] epat(input int r, input int b);
    logic [63:0] v;
    for (int i = 0; i < IN; i++) v[i*8 +: 8] = pat(r, b, i);
    return v;
  endfunction

  function automatic logic [63:0] pk0();
    logic [63:0] v;
    for (int i = 0; i < IN; i++) v[i*8 +: 8] = do0[i];
    return v;
  endfunction

  function automatic logic [63:0] pk1();
    logic [63:0] v;
    for (int i = 0; i < IN; i++) v[i*8 +: 8] = do1[i];
    return v;
  endfunction

  task automatic set0(input int r, input int b);
    for (int i = 0; i < IN; i++) rd0[(r*IN+i)*DW +: DW] = pat(r, b, i);
  endtask

  task automatic set1(input int r, input int b);
    for (int i = 0; i < IN; i++) rd1[(r*IN+i)*DW +: DW] = pat(r, b, i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_id;
    rst0 = 1'b1; rst1 = 1'b1;
    rd0 = '0; rd1 = '0; rv0 = '0; rv1 = '0;
    ordy0 = 1'b1; ordy1 = 1'b1;
    step(); step();

    // Reset state; ready held low under reset even with a valid request.
    rv0 = 4'b0001;
    #1;
    chk("rst_ready", 64'(rr0), 64'h0);
    chk("rst_valid", 64'(dv0), 64'h0);
    chk("rst_gid",   64'(gid0), 64'h0);
    chk("rst_data",  pk0(), 64'h0);

    // Single requester, three back-to-back beats.
    rst0 = 1'b0;
    set0(0, 0);
    #1;
    chk("t1_ready0", 64'(rr0), 64'h1);
    step();
    chk("t1_a_valid", 64'(dv0), 64'h1);
    chk("t1_a_gid",   64'(gid0), 64'h0);
    chk("t1_a_data",  pk0(), epat(0, 0));
    set0(0, 1);
    step();
    chk("t1_b_valid", 64'(dv0), 64'h1);
    chk("t1_b_data",  pk0(), epat(0, 1));
    set0(0, 2);
    step();
    chk("t1_c_valid", 64'(dv0), 64'h1);
    chk("t1_c_data",  pk0(), epat(0, 2));
    rv0 = 4'b0000;
    step();
    chk("t1_drain", 64'(dv0), 64'h0);

    // All four requesters valid: bursts of four in round-robin order from 0.
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    for (int r = 0; r < NR; r++) set0(r, 1);
    rv0 = 4'b1111;
    for (int n = 0; n < 20; n++) begin
      #1;
      chk("t2_onehot", 64'($countones(rr0)), 64'h1);
      step();
      exp_id = (n / 4) % 4;
      chk("t2_gid",  64'(gid0), 64'(exp_id));
      chk("t2_data", pk0(), epat(exp_id, 1));
    end

    // Stall the sink two beats into requester 1's burst.
    step();
    chk("t4_pre1", 64'(gid0), 64'h1);
    step();
    chk("t4_pre2", 64'(gid0), 64'h1);
    ordy0 = 1'b0;
    set0(1, 2);
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("t4_ready_low", 64'(rr0), 64'h0);
      step();
      chk("t4_hold_valid", 64'(dv0), 64'h1);
      chk("t4_hold_gid",   64'(gid0), 64'h1);
      chk("t4_hold_data",  pk0(), epat(1, 1));
    end
    ordy0 = 1'b1;
    #1;
    chk("t4_resume_ready", 64'(rr0), 64'h2);
    step();
    chk("t4_b3_gid",  64'(gid0), 64'h1);
    chk("t4_b3_data", pk0(), epat(1, 2));
    step();
    chk("t4_b4_gid",  64'(gid0), 64'h1);
    step();
    chk("t4_next_gid", 64'(gid0), 64'h2);
    chk("t4_next_data", pk0(), epat(2, 1));

    // Reset in the middle of requester 2's burst.
    rst0 = 1'b1;
    #1;
    chk("t6_ready_rst", 64'(rr0), 64'h0);
    step();
    chk("t6_valid", 64'(dv0), 64'h0);
    chk("t6_gid",   64'(gid0), 64'h0);
    chk("t6_data",  pk0(), 64'h0);

    // Owner 0 drops valid after two beats while requester 2 waits.
    rst0 = 1'b0;
    rv0 = 4'b0101;
    set0(0, 0);
    set0(2, 0);
    #1;
    chk("t6_first_prio", 64'(rr0), 64'h1);
    step();
    chk("t5_b1_gid",  64'(gid0), 64'h0);
    chk("t5_b1_data", pk0(), epat(0, 0));
    set0(0, 1);
    step();
    chk("t5_b2_data", pk0(), epat(0, 1));
    rv0 = 4'b0100;
    #1;
    chk("t5_owner_ready", 64'(rr0), 64'h1);
    step();
    chk("t5_bubble", 64'(dv0), 64'h0);
    chk("t5_ready2", 64'(rr0), 64'h4);
    step();
    chk("t5_g2_valid", 64'(dv0), 64'h1);
    chk("t5_g2_gid",   64'(gid0), 64'h2);
    chk("t5_g2_data",  pk0(), epat(2, 0));

    // BURST=1 instance: requesters 1 and 3 alternate every beat.
    chk("t3_rst_valid", 64'(dv1), 64'h0);
    rst1 = 1'b0;
    rv1 = 4'b1010;
    set1(1, 3);
    set1(3, 5);
    #1;
    chk("t3_ready1", 64'(rr1), 64'h2);
    step();
    chk("t3_g0", 64'(gid1), 64'h1);
    chk("t3_d0", pk1(), epat(1, 3));
    chk("t3_ready3", 64'(rr1), 64'h8);
    step();
    chk("t3_g1", 64'(gid1), 64'h3);
    chk("t3_d1", pk1(), epat(3, 5));
    step();
    chk("t3_g2", 64'(gid1), 64'h1);
    step();
    chk("t3_g3", 64'(gid1), 64'h3);
    chk("t3_v3", 64'(dv1), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
